apb_timer: RTL
==============

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 The block SHALL be an APB slave timer placed directly downstream of the AHB-to-APB bridge, consuming its PSEL/PENABLE/PWRITE/PADDR/PWDATA and returning PRDATA/PREADY.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 PCLK  in  1  clock; all state changes on rising edge.
REQ-004 PRESET  in  1  synchronous active-high reset.
REQ-005 PSEL  in  1  slave select.
REQ-006 PENABLE  in  1  access phase.
REQ-007 PWRITE  in  1  1=write, 0=read.
REQ-008 PADDR  in  32  byte address; only PADDR[11:0] decoded.
REQ-009 PWDATA  in  32  write data.
REQ-010 PRDATA  out  32  read data, registered.
REQ-011 PREADY  out  1  transfer complete, registered.
REQ-012 PSLVERR  out  1  transfer error, valid only while PREADY=1.
REQ-013 IRQ  out  1  level interrupt = STATUS.FLAG & CTRL.IRQEN.

Function
REQ-014 Register map (PADDR[11:4] must be 0): 0x00 CTRL (bit0 EN, bit1 RELOAD, bit2 IRQEN, others read 0); 0x04 LOAD (RW, 32b); 0x08 VALUE (RO); 0x0C STATUS (bit0 FLAG, write-1-to-clear).
REQ-015 Handshake FSM states: IDLE, DONE.
REQ-016 IDLE -> DONE when PSEL=1 and PENABLE=1; PREADY=0 during that first access cycle (exactly one wait state).
REQ-017 In DONE, PREADY=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 On the IDLE->DONE edge, PRDATA and PSLVERR SHALL be loaded; PRDATA=0 on writes or errors.
REQ-019 Writes SHALL commit on the clock edge ending the DONE cycle, only if PSEL=1, PENABLE=1 and PSLVERR=0.
REQ-020 PSLVERR=1: nonzero PADDR[11:4], PADDR[1:0]!=0, or write to VALUE; no register changes on error.
REQ-021 PSEL dropping in DONE (protocol violation): return to IDLE, no write.
REQ-022 Counter: when EN=1 and VALUE!=0, VALUE decrements by 1 per PCLK.
REQ-023 When EN=1 and VALUE=0: FLAG<=1; if RELOAD=1 then VALUE<=LOAD, else EN<=0 and VALUE held at 0.
REQ-024 A committed LOAD write SHALL also set VALUE<=PWDATA, overriding decrement/reload that cycle.
REQ-025 A committed CTRL write takes precedence over the auto-clear of EN in the same cycle.
REQ-026 FLAG set and STATUS W1C in the same cycle: set wins, FLAG=1.
REQ-027 LOAD=0 with RELOAD=1, EN=1: FLAG asserts every cycle; no underflow, VALUE stays 0.

Reset
REQ-028 PRESET=1 SHALL force: FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, CTRL=0, LOAD=0, VALUE=0, FLAG=0, IRQ=0.
REQ-029 Reset mid-transfer SHALL abort it with no register update; PREADY low the cycle after reset.

Structure
REQ-030 Package apb_timer_pkg SHALL hold register offsets, CTRL bit indices and the FSM state enum.
REQ-031 The down-counter with reload and FLAG logic SHALL be sub-module apb_timer_counter; APB decode and FSM stay in apb_timer.

Verification
REQ-032 Write LOAD=5, CTRL=0x3 -> VALUE reads 5..0 sequence, FLAG sets at 0, VALUE reloads to 5 next cycle.
REQ-033 LOAD=3, CTRL=0x5 (no reload) -> VALUE hits 0, EN clears, IRQ=1; write STATUS=1 -> IRQ=0.
REQ-034 Any read -> PREADY=0 in first access cycle, PREADY=1 in second, PRDATA valid with it.
REQ-035 Write VALUE or read address 0x010 -> PSLVERR=1 with PREADY, PRDATA=0, no state change.
REQ-036 Issue W1C to STATUS on the exact cycle VALUE reaches 0 -> FLAG remains 1.
REQ-037 Assert PRESET in DONE of a LOAD write of 0xA5 -> LOAD stays 0, PREADY=0 next cycle.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit positions,
// handshake FSM states and the address/access error decode.
package apb_timer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h4;
  localparam logic [3:0] OFF_VALUE  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQEN  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // Out-of-window, misaligned, or a write to the read-only VALUE register.
  function automatic logic addr_err(input logic [11:0] addr, input logic wr);
    return (addr[11:4] != 8'd0) || (addr[1:0] != 2'd0) ||
           (wr && (addr[3:0] == OFF_VALUE));
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB slave-side bus bundle for the timer (clock and reset stay separate).
interface apb_timer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_counter.sv
// Down-counter with optional auto-reload, terminal-count FLAG and the
// CTRL/LOAD/STATUS storage it depends on.
module apb_timer_counter
  import apb_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_we,
  input  logic        load_we,
  input  logic        status_w1c,
  input  logic [31:0] wdata,
  output logic [2:0]  ctrl,
  output logic [31:0] load,
  output logic [31:0] value,
  output logic        flag
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        flag_q, flag_d;

  // Next state: count, terminal count, then bus writes layered on top so
  // they win over the automatic updates of the same cycle.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    value_d = value_q;
    flag_d  = flag_q;
    if (status_w1c) flag_d = 1'b0;
    if (ctrl_q[CTRL_EN]) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        flag_d = 1'b1;
        if (ctrl_q[CTRL_RELOAD]) value_d = load_q;
        else                     ctrl_d[CTRL_EN] = 1'b0;
      end
    end
    if (ctrl_we) ctrl_d = wdata[2:0];
    if (load_we) begin
      load_d  = wdata;
      value_d = wdata;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      value_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      value_q <= value_d;
      flag_q  <= flag_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign load  = load_q;
  assign value = value_q;
  assign flag  = flag_q;

endmodule

// File: rtl/apb_timer.sv
// APB timer top: bus decode, one-wait-state handshake FSM, read mux and IRQ.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for an access phase; PREADY low
//   ST_DONE | PREADY high for one cycle; writes commit at the end of it
module apb_timer
  import apb_timer_pkg::*;
(
  input  logic        pclk,
  input  logic        preset,
  apb_timer_if.slave  apb,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;

  logic [3:0]  off;
  logic        access;
  logic        commit;
  logic [31:0] rd_data;
  logic        ctrl_we, load_we, status_w1c;
  logic [2:0]  ctrl;
  logic [31:0] load, value;
  logic        flag;
  logic        unused_paddr_hi;

  assign unused_paddr_hi = ^apb.paddr[31:12];

  // Address decode, commit qualification and register read mux.
  always_comb begin
    off        = apb.paddr[3:0];
    access     = apb.psel && apb.penable;
    commit     = (state_q == ST_DONE) && access && !pslverr_q && apb.pwrite;
    ctrl_we    = commit && (off == OFF_CTRL);
    load_we    = commit && (off == OFF_LOAD);
    status_w1c = commit && (off == OFF_STATUS) && apb.pwdata[0];
    case (off)
      OFF_CTRL:   rd_data = {29'd0, ctrl};
      OFF_LOAD:   rd_data = load;
      OFF_VALUE:  rd_data = value;
      OFF_STATUS: rd_data = {31'd0, flag};
      default:    rd_data = 32'd0;
    endcase
  end

  // Handshake next state; response data and error are captured on IDLE->DONE.
  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = addr_err(apb.paddr[11:0], apb.pwrite);
          prdata_d  = (apb.pwrite || pslverr_d) ? 32'd0 : rd_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_timer_counter u_counter (
    .clk        (pclk),
    .rst        (preset),
    .ctrl_we    (ctrl_we),
    .load_we    (load_we),
    .status_w1c (status_w1c),
    .wdata      (apb.pwdata),
    .ctrl       (ctrl),
    .load       (load),
    .value      (value),
    .flag       (flag)
  );

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign irq         = flag & ctrl[CTRL_IRQEN];

endmodule
